// File: rtl/vscale_dmem_responder.sv
// vscale_dmem_responder: single-port data memory slave with a fixed wait-state count and fault detection
module vscale_dmem_responder #(
  parameter int WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic [3:0] cnt;
  logic [AW-1:0] idx_q;
  logic [1:0] off_q;
  logic wen_q, fault_q;
  logic [2:0] size_q;
  logic [31:0] mem [WORDS];
  logic req_fault, busy, done_ok, accept;
  logic [31:0] sh, wd;
  logic [3:0] be;
  assign req_fault = (dmem_size == 3'd3) || (dmem_size[2:1] == 2'b11) || (dmem_wen && dmem_size[2])
                  || (dmem_size[1:0] == 2'd1 && dmem_addr[0])
                  || (dmem_size[1:0] == 2'd2 && dmem_addr[1:0] != 2'd0)
                  || ({2'b00, dmem_addr[31:2]} >= 32'(WORDS));
  assign busy = (state == BUSY);
  assign done_ok = busy && !fault_q && cnt == 4'd0;
  assign dmem_wait = busy && !fault_q && cnt != 4'd0;
  assign dmem_badmem_e = busy && fault_q;
  assign accept = dmem_en && !dmem_wait;
  assign sh = mem[idx_q] >> {off_q, 3'b000};
  assign wd = dmem_wdata << {off_q, 3'b000};
  always_comb begin
    be = (size_q[1:0] == 2'd0) ? (4'b0001 << off_q) : (size_q[1:0] == 2'd1) ? (4'b0011 << off_q) : 4'b1111;
    dmem_rdata = !(done_ok && !wen_q) ? 32'd0 :
                 (size_q == 3'd0) ? {{24{sh[7]}}, sh[7:0]} :
                 (size_q == 3'd1) ? {{16{sh[15]}}, sh[15:0]} :
                 (size_q == 3'd4) ? {24'd0, sh[7:0]} :
                 (size_q == 3'd5) ? {16'd0, sh[15:0]} : sh;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      idx_q <= '0;
      off_q <= 2'd0;
      wen_q <= 1'b0;
      size_q <= 3'd0;
      fault_q <= 1'b0;
    end else if (accept) begin
      state <= BUSY;
      cnt <= 4'(LATENCY);
      idx_q <= dmem_addr[AW+1:2];
      off_q <= dmem_addr[1:0];
      wen_q <= dmem_wen;
      size_q <= dmem_size;
      fault_q <= req_fault;
    end else if (busy && (fault_q || cnt == 4'd0)) begin
      state <= IDLE;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
    end
  end
  // Memory has no reset; a reset clears state, which suppresses any pending write.
  always_ff @(posedge clk) begin
    if (done_ok && wen_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx_q][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_vscale_dmem_responder.sv
// tb_vscale_dmem_responder: directed checks of the data memory responder at LATENCY=2 and LATENCY=0
module tb_vscale_dmem_responder;
  logic clk, reset;
  logic en, wen, bad, wt;
  logic [2:0] size;
  logic [31:0] addr, wdata, rdata;
  logic en0, wen0, bad0, wt0;
  logic [2:0] size0;
  logic [31:0] addr0, wdata0, rdata0;
  int errors = 0, checks = 0;
  logic leak;
  logic [31:0] rd;
  int waits;
  logic b;

  vscale_dmem_responder #(.WORDS(1024), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .dmem_en(en), .dmem_wen(wen), .dmem_size(size),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_rdata(rdata), .dmem_wait(wt), .dmem_badmem_e(bad));
  vscale_dmem_responder #(.WORDS(1024), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .dmem_en(en0), .dmem_wen(wen0), .dmem_size(size0),
    .dmem_addr(addr0), .dmem_wdata(wdata0), .dmem_rdata(rdata0), .dmem_wait(wt0), .dmem_badmem_e(bad0));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic access(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r, output int n, output logic f);
    en = 1; wen = w; size = s; addr = a; wdata = d;
    @(posedge clk); #1 en = 0;
    n = 0;
    @(negedge clk);
    while (wt && n < 20) begin
      if (rdata !== 32'd0 || bad) leak = 1;
      n++;
      @(negedge clk);
    end
    r = rdata; f = bad;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1; en = 0; wen = 0; size = 0; addr = 0; wdata = 0;
    en0 = 0; wen0 = 0; size0 = 0; addr0 = 0; wdata0 = 0; leak = 0;
    #2;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (wt !== 1'b0) begin errors++; $display("FAIL reset_wait got=%b exp=0", wt); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL reset_bad got=%b exp=0", bad); end
    @(posedge clk); @(posedge clk); #1 reset = 0;
  endtask

  task automatic test_word;
    access(1, 3'd2, 32'h10, 32'hDEADBEEF, rd, waits, b);
    checks++; if (waits !== 2) begin errors++; $display("FAIL sw_waits got=%0d exp=2", waits); end
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL sw_bad got=%b exp=0", b); end
    access(0, 3'd2, 32'h10, 32'h0, rd, waits, b);
    checks++; if (waits !== 2) begin errors++; $display("FAIL lw_waits got=%0d exp=2", waits); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL idle_rdata got=%h exp=0", rdata); end
  endtask

  task automatic test_byte;
    access(1, 3'd0, 32'h13, 32'h00000080, rd, waits, b);
    access(0, 3'd0, 32'h13, 32'h0, rd, waits, b);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got=%h exp=ffffff80", rd); end
    access(0, 3'd4, 32'h13, 32'h0, rd, waits, b);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got=%h exp=00000080", rd); end
    access(0, 3'd2, 32'h10, 32'h0, rd, waits, b);
    checks++; if (rd !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_after_sb got=%h exp=80adbeef", rd); end
    access(0, 3'd1, 32'h12, 32'h0, rd, waits, b);
    checks++; if (rd !== 32'hFFFF80AD) begin errors++; $display("FAIL lh got=%h exp=ffff80ad", rd); end
    access(0, 3'd5, 32'h10, 32'h0, rd, waits, b);
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu got=%h exp=0000beef", rd); end
    access(0, 3'd0, 32'h11, 32'h0, rd, waits, b);
    checks++; if (rd !== 32'hFFFFFFBE) begin errors++; $display("FAIL lb1 got=%h exp=ffffffbe", rd); end
    access(1, 3'd1, 32'h22, 32'h0000A1B2, rd, waits, b);
    access(0, 3'd2, 32'h20, 32'h0, rd, waits, b);
    checks++; if (rd[31:16] !== 16'hA1B2) begin errors++; $display("FAIL sh_upper got=%h exp=a1b2", rd[31:16]); end
  endtask

  task automatic test_faults;
    access(1, 3'd2, 32'h20, 32'h11223344, rd, waits, b);
    access(0, 3'd1, 32'h21, 32'h0, rd, waits, b);
    checks++; if (b !== 1'b1 || waits !== 0 || rd !== 32'd0) begin errors++; $display("FAIL lh_odd got=bad%b w%0d r%h exp=bad1 w0 r0", b, waits, rd); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bad_pulse got=%b exp=0", bad); end
    access(0, 3'd2, 32'h22, 32'h0, rd, waits, b);
    checks++; if (b !== 1'b1 || waits !== 0 || rd !== 32'd0) begin errors++; $display("FAIL lw_mis got=bad%b w%0d r%h exp=bad1 w0 r0", b, waits, rd); end
    access(0, 3'd3, 32'h0, 32'h0, rd, waits, b);
    checks++; if (b !== 1'b1 || waits !== 0) begin errors++; $display("FAIL size3 got=bad%b w%0d exp=bad1 w0", b, waits); end
    access(1, 3'd1, 32'h21, 32'h0000FFFF, rd, waits, b);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL sh_odd got=%b exp=1", b); end
    access(1, 3'd4, 32'h20, 32'h000000EE, rd, waits, b);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL store_bu got=%b exp=1", b); end
    access(1, 3'd7, 32'h20, 32'h000000EE, rd, waits, b);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL size7 got=%b exp=1", b); end
    access(0, 3'd2, 32'h20, 32'h0, rd, waits, b);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL fault_nowrite got=%h exp=11223344", rd); end
  endtask

  task automatic test_bounds;
    access(0, 3'd2, 32'h1000, 32'h0, rd, waits, b);
    checks++; if (b !== 1'b1 || waits !== 0) begin errors++; $display("FAIL oob got=bad%b w%0d exp=bad1 w0", b, waits); end
    access(1, 3'd2, 32'hFFC, 32'h0BADF00D, rd, waits, b);
    access(0, 3'd2, 32'hFFC, 32'h0, rd, waits, b);
    checks++; if (b !== 1'b0 || waits !== 2 || rd !== 32'h0BADF00D) begin errors++; $display("FAIL top_word got=bad%b w%0d r%h exp=bad0 w2 r0badf00d", b, waits, rd); end
  endtask

  task automatic test_back_to_back;
    en0 = 1; wen0 = 1; size0 = 3'd2; addr0 = 32'h4; wdata0 = 32'h12345678;
    @(posedge clk); #1 wen0 = 0;
    checks++; if (wt0 !== 1'b0 || bad0 !== 1'b0) begin errors++; $display("FAIL b2b_store got=w%b bad%b exp=w0 bad0", wt0, bad0); end
    @(posedge clk); #1 en0 = 0;
    checks++; if (wt0 !== 1'b0 || rdata0 !== 32'h12345678) begin errors++; $display("FAIL b2b_load got=w%b r%h exp=w0 r12345678", wt0, rdata0); end
    @(posedge clk); #1;
    checks++; if (rdata0 !== 32'd0) begin errors++; $display("FAIL b2b_idle got=%h exp=0", rdata0); end
  endtask

  task automatic test_reset_busy;
    access(1, 3'd2, 32'h8, 32'hCAFEF00D, rd, waits, b);
    en = 1; wen = 1; size = 3'd2; addr = 32'h8; wdata = 32'h55;
    @(posedge clk); #1 en = 0;
    checks++; if (wt !== 1'b1) begin errors++; $display("FAIL busy_wait got=%b exp=1", wt); end
    #2 reset = 1;
    #1;
    checks++; if (wt !== 1'b0 || bad !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL async_reset got=w%b bad%b r%h exp=0 0 0", wt, bad, rdata); end
    @(posedge clk); #1 reset = 0;
    access(0, 3'd2, 32'h8, 32'h0, rd, waits, b);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL reset_nowrite got=%h exp=cafef00d", rd); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_faults;
    test_bounds;
    test_back_to_back;
    test_reset_busy;
    checks++; if (leak !== 1'b0) begin errors++; $display("FAIL wait_cycle_outputs got=%b exp=0", leak); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
